// File: rtl/alu_dp_pkg.sv
// Shared encodings for alu_datapath_unit: ALU opcodes and the sequencing FSM states.
package alu_dp_pkg;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_SLL   = 4'd5;
  localparam logic [3:0] OP_SRL   = 4'd6;
  localparam logic [3:0] OP_SLT   = 4'd7;
  localparam logic [3:0] OP_PASSB = 4'd8;
  localparam logic [3:0] OP_MUL   = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MULT = 2'd2
  } alu_state_t;

endpackage

// File: rtl/alu_seq_multiplier.sv
// Iterative shift-add multiplier: one partial product per cycle, low WIDTH bits of a*b.
// done is high during the final iteration; product then holds the completed result.
module alu_seq_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [CW-1:0]    count;
  logic             running;

  // Product is exposed combinationally so the caller can latch it on the last iteration edge.
  assign acc_next = acc + (mplier[0] ? mcand : '0);
  assign product  = acc_next;
  assign done     = running && (count == CW'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      count   <= '0;
      running <= 1'b0;
    end else if (start) begin
      mcand   <= a;
      mplier  <= b;
      acc     <= '0;
      count   <= CW'(WIDTH);
      running <= 1'b1;
    end else if (running) begin
      acc     <= acc_next;
      mcand   <= mcand << 1;
      mplier  <= mplier >> 1;
      count   <= count - CW'(1);
      if (count == CW'(1)) running <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_datapath_unit.sv
// ALU centre with operand muxes, ALUOut/SP registers and start/busy/done handshake.
// Define ALU_DP_MUL_EN to build the iterative multiplier; otherwise OP_MUL reports illegal_op.
module alu_datapath_unit
  import alu_dp_pkg::*;
#(
  parameter int               WIDTH   = 16,
  parameter int               NSRC    = 4,
  parameter logic [WIDTH-1:0] SP_INIT = WIDTH'(16'h03FF)
) (
  input  logic                      CLK,
  input  logic                      reset,
  input  logic                      start,
  input  logic [3:0]                ALU_op,
  input  logic [$clog2(NSRC)-1:0]   srcA_sel,
  input  logic [NSRC*WIDTH-1:0]     srcA_bus,
  input  logic [$clog2(NSRC)-1:0]   srcB_sel,
  input  logic [NSRC*WIDTH-1:0]     srcB_bus,
  input  logic                      ALUOutWrite,
  input  logic                      SpWrite,
  output logic                      busy,
  output logic                      done,
  output logic [WIDTH-1:0]          ALUOutOut,
  output logic [WIDTH-1:0]          SPOut,
  output logic                      BranchResult,
  output logic                      BLEResult,
  output logic                      illegal_op
);

  localparam int SEL_W = $clog2(NSRC);
  localparam int SH_W  = $clog2(WIDTH);

  alu_state_t       state_q, state_d;
  logic [WIDTH-1:0] a_mux, b_mux;
  logic [WIDTH-1:0] a_q, b_q;
  logic [3:0]       op_q;
  logic             wr_alu_q, wr_sp_q;
  logic [WIDTH-1:0] alu_res, result;
  logic             alu_illegal, res_illegal, complete;

`ifdef ALU_DP_MUL_EN
  logic             mul_start, mul_done;
  logic [WIDTH-1:0] mul_product;

  alu_seq_multiplier #(.WIDTH(WIDTH)) u_mul (
    .clk     (CLK),
    .reset   (reset),
    .start   (mul_start),
    .a       (a_mux),
    .b       (b_mux),
    .done    (mul_done),
    .product (mul_product)
  );
`endif

  // Out-of-range selects fall through to a zero operand.
  always_comb begin
    a_mux = '0;
    b_mux = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (srcA_sel == SEL_W'(i)) a_mux = srcA_bus[i*WIDTH +: WIDTH];
      if (srcB_sel == SEL_W'(i)) b_mux = srcB_bus[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    alu_res     = '0;
    alu_illegal = 1'b0;
    case (op_q)
      OP_ADD:   alu_res = a_q + b_q;
      OP_SUB:   alu_res = a_q - b_q;
      OP_AND:   alu_res = a_q & b_q;
      OP_OR:    alu_res = a_q | b_q;
      OP_XOR:   alu_res = a_q ^ b_q;
      OP_SLL:   alu_res = a_q << b_q[SH_W-1:0];
      OP_SRL:   alu_res = a_q >> b_q[SH_W-1:0];
      OP_SLT:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      OP_PASSB: alu_res = b_q;
      default:  alu_illegal = 1'b1;
    endcase
  end

  assign busy = (state_q != IDLE);

  always_comb begin
    state_d     = state_q;
    complete    = 1'b0;
    result      = alu_res;
    res_illegal = alu_illegal;
`ifdef ALU_DP_MUL_EN
    mul_start   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
`ifdef ALU_DP_MUL_EN
          if (ALU_op == OP_MUL) begin
            state_d   = MULT;
            mul_start = 1'b1;
          end else begin
            state_d = EXEC;
          end
`else
          state_d = EXEC;
`endif
        end
      end
      EXEC: begin
        complete = 1'b1;
        state_d  = IDLE;
      end
      MULT: begin
`ifdef ALU_DP_MUL_EN
        if (mul_done) begin
          complete    = 1'b1;
          result      = mul_product;
          res_illegal = 1'b0;
          state_d     = IDLE;
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // Both destination registers load the fresh result on the same edge when both enables were captured.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      wr_alu_q     <= 1'b0;
      wr_sp_q      <= 1'b0;
      ALUOutOut    <= '0;
      SPOut        <= SP_INIT;
      done         <= 1'b0;
      BranchResult <= 1'b0;
      BLEResult    <= 1'b0;
      illegal_op   <= 1'b0;
    end else begin
      state_q    <= state_d;
      done       <= complete;
      illegal_op <= complete && res_illegal;
      if (state_q == IDLE && start) begin
        a_q      <= a_mux;
        b_q      <= b_mux;
        op_q     <= ALU_op;
        wr_alu_q <= ALUOutWrite;
        wr_sp_q  <= SpWrite;
      end
      if (complete) begin
        BranchResult <= (a_q == b_q);
        BLEResult    <= ($signed(a_q) <= $signed(b_q));
        if (!res_illegal) begin
          if (wr_alu_q) ALUOutOut <= result;
          if (wr_sp_q)  SPOut     <= result;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_datapath_unit.sv
// Directed-vector bench for alu_datapath_unit (NSRC=3 so select value 3 exercises the zero operand).
// Expectations follow ALU_DP_MUL_EN when it is defined for the build.
module tb_alu_datapath_unit;
  import alu_dp_pkg::*;

  localparam int WIDTH = 16;
  localparam int NSRC  = 3;

  logic                  CLK = 1'b0;
  logic                  reset, start;
  logic [3:0]            ALU_op;
  logic [1:0]            srcA_sel, srcB_sel;
  logic [NSRC*WIDTH-1:0] srcA_bus, srcB_bus;
  logic                  ALUOutWrite, SpWrite;
  logic                  busy, done, BranchResult, BLEResult, illegal_op;
  logic [WIDTH-1:0]      ALUOutOut, SPOut;

  int checks = 0;
  int errors = 0;

  alu_datapath_unit #(.WIDTH(WIDTH), .NSRC(NSRC), .SP_INIT(16'h03FF)) dut (
    .CLK          (CLK),
    .reset        (reset),
    .start        (start),
    .ALU_op       (ALU_op),
    .srcA_sel     (srcA_sel),
    .srcA_bus     (srcA_bus),
    .srcB_sel     (srcB_sel),
    .srcB_bus     (srcB_bus),
    .ALUOutWrite  (ALUOutWrite),
    .SpWrite      (SpWrite),
    .busy         (busy),
    .done         (done),
    .ALUOutOut    (ALUOutOut),
    .SPOut        (SPOut),
    .BranchResult (BranchResult),
    .BLEResult    (BLEResult),
    .illegal_op   (illegal_op)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [3:0]  op;
    logic [1:0]  sa;
    logic [15:0] a;
    logic [1:0]  sb;
    logic [15:0] b;
    logic        wa;
    logic        ws;
    logic [15:0] exp_out;
    logic [15:0] exp_sp;
    logic        exp_br;
    logic        exp_ble;
    logic        exp_ill;
  } vec_t;

  vec_t vecs [16];

  task automatic check_output(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Slot 0 carries a, slot 1 carries b, slot 2 a fixed 0300; controls are scrambled after accept.
  task automatic apply_stimulus(input vec_t v, input string tag);
    srcA_bus    = {16'h0300, v.b, v.a};
    srcB_bus    = {16'h0300, v.b, v.a};
    srcA_sel    = v.sa;
    srcB_sel    = v.sb;
    ALU_op      = v.op;
    ALUOutWrite = v.wa;
    SpWrite     = v.ws;
    start       = 1'b1;
    @(posedge CLK) #1;
    start       = 1'b0;
    srcA_bus    = {3{16'h7777}};
    srcB_bus    = {3{16'h5555}};
    ALU_op      = OP_XOR;
    ALUOutWrite = ~v.wa;
    SpWrite     = ~v.ws;
    check_output({tag, " busy"}, 16'(busy), 16'd1);
    check_output({tag, " early done"}, 16'(done), 16'd0);
    @(posedge CLK) #1;
    check_output({tag, " done"}, 16'(done), 16'd1);
    check_output({tag, " busy clear"}, 16'(busy), 16'd0);
    check_output({tag, " ALUOutOut"}, ALUOutOut, v.exp_out);
    check_output({tag, " SPOut"}, SPOut, v.exp_sp);
    check_output({tag, " BranchResult"}, 16'(BranchResult), 16'(v.exp_br));
    check_output({tag, " BLEResult"}, 16'(BLEResult), 16'(v.exp_ble));
    check_output({tag, " illegal_op"}, 16'(illegal_op), 16'(v.exp_ill));
    @(posedge CLK) #1;
    check_output({tag, " done pulse width"}, 16'(done), 16'd0);
    check_output({tag, " illegal pulse width"}, 16'(illegal_op), 16'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int  n;
    logic seen_done;

    reset = 1'b1; start = 1'b0; ALU_op = OP_ADD;
    srcA_sel = '0; srcB_sel = '0; srcA_bus = '0; srcB_bus = '0;
    ALUOutWrite = 1'b0; SpWrite = 1'b0;
    repeat (2) @(posedge CLK);
    #1 reset = 1'b0;
    check_output("reset ALUOutOut", ALUOutOut, 16'h0000);
    check_output("reset SPOut", SPOut, 16'h03FF);
    check_output("reset busy", 16'(busy), 16'd0);
    check_output("reset done", 16'(done), 16'd0);
    check_output("reset BranchResult", 16'(BranchResult), 16'd0);
    check_output("reset BLEResult", 16'(BLEResult), 16'd0);
    check_output("reset illegal_op", 16'(illegal_op), 16'd0);

    //              op        sa    a         sb    b         wa    ws    out       sp        br    ble   ill
    vecs[0]  = '{OP_ADD,   2'd0, 16'h7FFF, 2'd1, 16'h0001, 1'b1, 1'b0, 16'h8000, 16'h03FF, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{OP_SUB,   2'd0, 16'h0005, 2'd1, 16'h0005, 1'b1, 1'b1, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{OP_AND,   2'd0, 16'hF0F0, 2'd1, 16'h3C3C, 1'b1, 1'b0, 16'h3030, 16'h0000, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{OP_OR,    2'd0, 16'h1200, 2'd1, 16'h0034, 1'b0, 1'b1, 16'h3030, 16'h1234, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{OP_XOR,   2'd0, 16'hFFFF, 2'd1, 16'h00FF, 1'b1, 1'b0, 16'hFF00, 16'h1234, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{OP_SLL,   2'd0, 16'h0001, 2'd1, 16'h0013, 1'b1, 1'b0, 16'h0008, 16'h1234, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{OP_SRL,   2'd0, 16'h8000, 2'd1, 16'h000F, 1'b1, 1'b0, 16'h0001, 16'h1234, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{OP_SLT,   2'd0, 16'h0005, 2'd1, 16'hFFFF, 1'b1, 1'b0, 16'h0000, 16'h1234, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{OP_SLT,   2'd0, 16'hFFFE, 2'd1, 16'h0003, 1'b1, 1'b0, 16'h0001, 16'h1234, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{OP_PASSB, 2'd0, 16'h1111, 2'd1, 16'hABCD, 1'b1, 1'b1, 16'hABCD, 16'hABCD, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{OP_ADD,   2'd0, 16'h0007, 2'd1, 16'h0007, 1'b0, 1'b0, 16'hABCD, 16'hABCD, 1'b1, 1'b1, 1'b0};
    vecs[11] = '{4'hF,     2'd0, 16'h0001, 2'd1, 16'h0002, 1'b1, 1'b1, 16'hABCD, 16'hABCD, 1'b0, 1'b1, 1'b1};
    vecs[12] = '{OP_ADD,   2'd0, 16'hFFFF, 2'd1, 16'h0002, 1'b1, 1'b0, 16'h0001, 16'hABCD, 1'b0, 1'b1, 1'b0};
    vecs[13] = '{OP_ADD,   2'd2, 16'h0000, 2'd1, 16'h0004, 1'b1, 1'b0, 16'h0304, 16'hABCD, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{OP_ADD,   2'd3, 16'h9999, 2'd1, 16'h0042, 1'b1, 1'b0, 16'h0042, 16'hABCD, 1'b0, 1'b1, 1'b0};
    vecs[15] = '{OP_PASSB, 2'd0, 16'h1234, 2'd3, 16'h8888, 1'b0, 1'b1, 16'h0042, 16'h0000, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 16; i++) apply_stimulus(vecs[i], $sformatf("v%0d", i));

    // Multiply with a stray start pulse in the middle; the stray request must be dropped.
    srcA_bus = {16'h0300, 16'h0034, 16'h0012};
    srcB_bus = {16'h0300, 16'h0034, 16'h0012};
    srcA_sel = 2'd0; srcB_sel = 2'd1;
    ALU_op = OP_MUL; ALUOutWrite = 1'b1; SpWrite = 1'b0; start = 1'b1;
    @(posedge CLK) #1;
    start = 1'b0;
    srcA_bus = {3{16'h7777}}; srcB_bus = {3{16'h5555}};
    ALU_op = OP_ADD; ALUOutWrite = 1'b1; SpWrite = 1'b1;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      if (n == 5) start = 1'b1;
      if (n == 6) start = 1'b0;
      @(posedge CLK) #1;
    end
    start = 1'b0;
`ifdef ALU_DP_MUL_EN
    check_output("mul busy cycles", 16'(n), 16'd16);
    check_output("mul ALUOutOut", ALUOutOut, 16'h03A8);
    check_output("mul illegal_op", 16'(illegal_op), 16'd0);
`else
    check_output("mul busy cycles", 16'(n), 16'd1);
    check_output("mul ALUOutOut", ALUOutOut, 16'h0042);
    check_output("mul illegal_op", 16'(illegal_op), 16'd1);
`endif
    check_output("mul done", 16'(done), 16'd1);
    check_output("mul SPOut", SPOut, 16'h0000);
    check_output("mul BranchResult", 16'(BranchResult), 16'd0);
    check_output("mul BLEResult", 16'(BLEResult), 16'd1);
    @(posedge CLK) #1;
    check_output("mul stray start ignored", 16'(busy), 16'd0);
    check_output("mul done pulse width", 16'(done), 16'd0);

    // Reset while a multiply is in flight: no write and no late done.
    srcA_bus = {16'h0300, 16'h0003, 16'h0003};
    srcB_bus = {16'h0300, 16'h0003, 16'h0003};
    ALU_op = OP_MUL; ALUOutWrite = 1'b1; SpWrite = 1'b1; start = 1'b1;
    @(posedge CLK) #1;
    start = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
`ifdef ALU_DP_MUL_EN
    check_output("mid-mul busy", 16'(busy), 16'd1);
`endif
    reset = 1'b1;
    repeat (2) @(posedge CLK);
    #1 reset = 1'b0;
    check_output("abort ALUOutOut", ALUOutOut, 16'h0000);
    check_output("abort SPOut", SPOut, 16'h03FF);
    check_output("abort busy", 16'(busy), 16'd0);
    seen_done = 1'b0;
    repeat (20) begin
      @(posedge CLK) #1;
      if (done) seen_done = 1'b1;
    end
    check_output("abort no done", 16'(seen_done), 16'd0);
    check_output("abort ALUOutOut held", ALUOutOut, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
